// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: initiator-side controller between the CPU MEM stage and a
// multi-cycle data RAM. It latches a load/store, holds cs/we/addr/din stable
// until the RAM drops ram_stall, returns read data and stalls the pipeline for
// the whole transaction. It then drives a one-cycle flush address so the next
// access always starts a fresh RAM handshake.
// Ports: clk/rst (async active-high); req/req_we/req_addr/req_wdata from the
// pipeline; cpu_stall/done/rdata/err/wait_cycles back to it; ram_cs/ram_we/
// ram_addr/ram_din to the RAM, ram_dout/ram_stall from it.
// Optional feature: define DMEM_TIMEOUT_EN to abort accesses after TIMEOUT
// WAIT cycles (err=1); without it err is tied to 0 and WAIT never times out.
module dmem_access_ctrl #(
  parameter int TIMEOUT   = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 cpu_stall,
  output logic                 done,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] wait_cycles,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic [31:0]          ram_addr,
  output logic [31:0]          ram_din,
  input  logic [31:0]          ram_dout,
  input  logic                 ram_stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
`endif

  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0] wcyc_q, wcyc_d;
  logic                 ram_cs_q, ram_cs_d;
  logic                 ram_we_q, ram_we_d;
  logic [31:0]          ram_addr_q, ram_addr_d;
  logic [31:0]          ram_din_q, ram_din_d;
`ifdef DMEM_TIMEOUT_EN
  logic                 err_q, err_d;
`endif

  // The ram_* registers are loaded with the value belonging to the *next*
  // state, so they change exactly on the state-transition edge and never
  // depend combinationally on req.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    wcyc_d     = wcyc_q;
    ram_cs_d   = ram_cs_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
`ifdef DMEM_TIMEOUT_EN
    err_d      = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        ram_cs_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = addr_q;
        ram_din_d  = '0;
        if (req) begin
          state_d    = S_WAIT;
          addr_d     = req_addr;
          we_d       = req_we;
          // Loads present zero on the data bus.
          wdata_d    = req_we ? req_wdata : 32'h0;
          cnt_d      = '0;
`ifdef DMEM_TIMEOUT_EN
          err_d      = 1'b0;
`endif
          ram_cs_d   = 1'b1;
          ram_we_d   = req_we;
          ram_addr_d = req_addr;
          ram_din_d  = req_we ? req_wdata : 32'h0;
        end
      end

      S_WAIT: begin
        // Saturating count of WAIT cycles seen so far.
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (!ram_stall) begin
          state_d    = S_DONE;
          wcyc_d     = cnt_q;
          if (!we_q) begin
            rdata_d = ram_dout;
          end
          ram_cs_d   = 1'b0;
          ram_we_d   = 1'b0;
          ram_addr_d = addr_q ^ 32'h1;  // flush address for the DONE cycle
          ram_din_d  = '0;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_C) begin
          state_d    = S_DONE;
          wcyc_d     = cnt_q;
          err_d      = 1'b1;
          ram_cs_d   = 1'b0;
          ram_we_d   = 1'b0;
          ram_addr_d = addr_q ^ 32'h1;
          ram_din_d  = '0;
        end
`endif
      end

      S_DONE: begin
        // req is ignored here; the pipeline advances this cycle.
        state_d    = S_IDLE;
        ram_cs_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = addr_q;
        ram_din_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      wcyc_q     <= '0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      wcyc_q     <= wcyc_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // The request cycle itself stalls, hence the combinational req term.
  assign cpu_stall   = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);
  assign done        = (state_q == S_DONE);
  assign rdata       = rdata_q;
  assign wait_cycles = wcyc_q;
  assign ram_cs      = ram_cs_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        cpu_stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [7:0]  wait_cycles;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_stall;

  dmem_access_ctrl #(.TIMEOUT(32), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .wait_cycles(wait_cycles),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_stall  (ram_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic [31:0] wcyc;
    logic        err;
    logic [31:0] flush;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd = 32'h0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        chk("done_not_consecutive", 32'(prev_done), 32'h0);
        chk("stall_in_done", 32'(cpu_stall), 32'h0);
        chk("cs_in_done", 32'(ram_cs), 32'h0);
        chk("we_in_done", 32'(ram_we), 32'h0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(sb_q.size()), 32'h1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("rdata", rdata, e.rdata);
          chk("wait_cycles", 32'(wait_cycles), e.wcyc);
          chk("err", 32'(err), 32'(e.err));
          chk("flush_addr", ram_addr, e.flush);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // One access with the RAM holding ram_stall high for n WAIT edges, then
  // acknowledging (or never acknowledging when abort is set).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input int n, input bit abort, input bit hold_req);
    exp_t e;
    int   acc;
    @(negedge clk);
    req       = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    ram_stall = 1'b1;
    #1;
    chk("stall_on_req", 32'(cpu_stall), 32'h1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold_req) req = 1'b0;
    e.cyc   = acc + n + 1;
    e.rdata = (we || abort) ? last_rd : rd;
    e.wcyc  = 32'(n);
    e.err   = abort;
    e.flush = addr ^ 32'h1;
    last_rd = e.rdata;
    sb_q.push_back(e);
    @(negedge clk);
    chk("wait_cs", 32'(ram_cs), 32'h1);
    chk("wait_we", 32'(ram_we), 32'(we));
    chk("wait_addr", ram_addr, addr);
    chk("wait_din", ram_din, we ? wdata : 32'h0);
    repeat (n) @(posedge clk);
    #1;
    chk("stall_in_wait", 32'(cpu_stall), 32'h1);
    chk("addr_held", ram_addr, addr);
    if (!abort) begin
      ram_stall = 1'b0;
      ram_dout  = rd;
    end
    @(posedge clk);
    #1;
    ram_stall = 1'b1;
    ram_dout  = 32'hDEAD_BEEF;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req       = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    ram_dout  = 32'hDEAD_BEEF;
    ram_stall = 1'b1;
    #12;
    chk("rst_cs", 32'(ram_cs), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_din", ram_din, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_wcyc", 32'(wait_cycles), 32'h0);
    chk("rst_stall_noreq", 32'(cpu_stall), 32'h0);
    req = 1'b1;
    #1;
    chk("rst_stall_req", 32'(cpu_stall), 32'h1);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Load, store, back-to-back loads, zero-wait load.
    do_access(1'b0, 32'd5, 32'h0, 32'h1234_5678, 8, 1'b0, 1'b0);
    do_access(1'b1, 32'd3, 32'hCAFE_0001, 32'h0, 3, 1'b0, 1'b0);
    do_access(1'b0, 32'd7, 32'h0, 32'hA1A1_0001, 8, 1'b0, 1'b0);
    do_access(1'b0, 32'd7, 32'h0, 32'hA2A2_0002, 8, 1'b0, 1'b0);
    do_access(1'b0, 32'd8, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b0);

    // Reset four cycles into WAIT: outputs drop at once, no completion.
    @(negedge clk);
    req      = 1'b1;
    req_we   = 1'b0;
    req_addr = 32'd9;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_cs", 32'(ram_cs), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_cs", 32'(ram_cs), 32'h0);
    chk("midrst_we", 32'(ram_we), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_stall", 32'(cpu_stall), 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst     = 1'b0;
    last_rd = 32'h0;

`ifdef DMEM_TIMEOUT_EN
    do_access(1'b0, 32'h10, 32'h0, 32'h0, 32, 1'b1, 1'b0);
`else
    do_access(1'b0, 32'h10, 32'h0, 32'h5555_AAAA, 100, 1'b0, 1'b0);
`endif
    do_access(1'b0, 32'd4, 32'h0, 32'h0000_600D, 1, 1'b0, 1'b0);

    // req held high continuously with alternating addresses.
    do_access(1'b0, 32'd1, 32'h0, 32'h1111_0001, 2, 1'b0, 1'b1);
    do_access(1'b1, 32'd2, 32'h2222_0002, 32'h0, 0, 1'b0, 1'b1);
    do_access(1'b0, 32'd1, 32'h0, 32'h1111_0003, 3, 1'b0, 1'b1);
    do_access(1'b0, 32'd2, 32'h0, 32'h2222_0004, 1, 1'b0, 1'b1);
    @(negedge clk);
    req = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    chk("idle_stall", 32'(cpu_stall), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
